// File: rtl/div_result_bcd_formatter_if.sv
// Handshake bundle between the divider, the BCD formatter and the result consumer.
// The slave side is the formatter; the master side is whoever drives it.
interface div_result_bcd_formatter_if #(
    parameter int QW = 4,
    parameter int RW = 5,
    parameter int QD = 2,
    parameter int RD = 2
);
    logic            in_valid;
    logic            in_ready;
    logic [QW-1:0]   in_q;
    logic [RW-1:0]   in_r;
    logic            out_valid;
    logic            out_ready;
    logic [4*QD-1:0] q_bcd;
    logic [4*RD-1:0] r_bcd;
    logic            busy;

    modport master (
        output in_valid, in_q, in_r, out_ready,
        input  in_ready, out_valid, q_bcd, r_bcd, busy
    );

    modport slave (
        input  in_valid, in_q, in_r, out_ready,
        output in_ready, out_valid, q_bcd, r_bcd, busy
    );
endinterface

// File: rtl/div_result_bcd_formatter.sv
// Converts one quotient/remainder pair to packed BCD with a double-dabble engine per
// operand, one shift-add-3 step per clock; holds the result until the consumer takes it.
module div_result_bcd_formatter #(
    parameter int QW = 4,
    parameter int RW = 5,
    parameter int QD = 2,
    parameter int RD = 2
) (
    input logic                       clk,
    input logic                       rst_n,
    div_result_bcd_formatter_if.slave bus
);
    localparam int N  = (QW > RW) ? QW : RW;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    function automatic longint unsigned pow10(input int digits);
        longint unsigned p = 1;
        for (int i = 0; i < digits; i++) p = p * 10;
        return p;
    endfunction

    if (pow10(QD) <= ((64'd1 << QW) - 64'd1)) begin : g_qd_too_small
        $error("QD BCD digits cannot hold the largest QW-bit quotient");
    end
    if (pow10(RD) <= ((64'd1 << RW) - 64'd1)) begin : g_rd_too_small
        $error("RD BCD digits cannot hold the largest RW-bit remainder");
    end
    if (N < 2) begin : g_n_too_small
        $error("operand width must be at least 2 bits");
    end

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    q_bin_q, q_bin_d, r_bin_q, r_bin_d;
    logic [4*QD-1:0] q_bcd_q, q_bcd_d, q_adj;
    logic [4*RD-1:0] r_bcd_q, r_bcd_d, r_adj;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    // Add-3 correction is purely per digit: no carry ripples between digits here.
    always_comb begin
        q_adj = q_bcd_q;
        r_adj = r_bcd_q;
        for (int i = 0; i < QD; i++) begin
            if (q_adj[4*i +: 4] >= 4'd5) q_adj[4*i +: 4] = q_adj[4*i +: 4] + 4'd3;
        end
        for (int i = 0; i < RD; i++) begin
            if (r_adj[4*i +: 4] >= 4'd5) r_adj[4*i +: 4] = r_adj[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        q_bin_d = q_bin_q;
        r_bin_d = r_bin_q;
        q_bcd_d = q_bcd_q;
        r_bcd_d = r_bcd_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    state_d = CONV;
                    q_bin_d = N'(bus.in_q);
                    r_bin_d = N'(bus.in_r);
                    q_bcd_d = '0;
                    r_bcd_d = '0;
                    cnt_d   = '0;
                end
            end
            CONV: begin
                q_bcd_d = {q_adj[4*QD-2:0], q_bin_q[N-1]};
                r_bcd_d = {r_adj[4*RD-2:0], r_bin_q[N-1]};
                q_bin_d = {q_bin_q[N-2:0], 1'b0};
                r_bin_d = {r_bin_q[N-2:0], 1'b0};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) state_d = DONE;
            end
            DONE: begin
                if (out_valid_q && bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Handshake outputs are registered copies of the next state, so in_ready
        // and out_valid can never be high in the same cycle.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == CONV);
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            q_bin_q     <= '0;
            r_bin_q     <= '0;
            q_bcd_q     <= '0;
            r_bcd_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            q_bin_q     <= q_bin_d;
            r_bin_q     <= r_bin_d;
            q_bcd_q     <= q_bcd_d;
            r_bcd_q     <= r_bcd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.q_bcd     = q_bcd_q;
    assign bus.r_bcd     = r_bcd_q;
endmodule
